// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, reads one word at a time
// from instruction memory over a req/ack handshake, buffers it as Instr for the
// controller/datapath and advances the PC when the instruction is consumed.
//
// Handshakes:
//   imem side : imem_req is a registered level, held in REQ_ST until a
//               one-cycle imem_ack strobe; imem_rdata is captured on that edge.
//   Instr side: instr_valid/instr_ready; a transfer (accept) happens on a rising
//               edge where both are 1. Instr and PC are stable while
//               instr_valid=1 and instr_ready=0. PCSrc/Result are sampled only
//               on accept.
//
// Optional feature, macro FETCH_TIMEOUT_EN: after TIMEOUT_CYCLES REQ_ST cycles
// without imem_ack, a NOP (MOV r0,r0) is delivered and fetch_err pulses once.
// Without the macro fetch_err is tied 0 and the unit waits forever for an ack.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] Instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        PCSrc,
  input  logic [31:0] Result,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8,
  output logic        fetch_err
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] NOP_INSTR        = 32'hE1A0_0000;

  typedef enum logic {
    REQ_ST  = 1'b0,
    HOLD_ST = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        req_q, req_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          timeout_hit;

  // The timeout fires on the edge that ends the TIMEOUT_CYCLES-th REQ_ST cycle.
  assign timeout_hit = (state_q == REQ_ST) && !imem_ack && (cnt_q == CNT_LIMIT);
`endif

  // Next-state, PC update and buffered-instruction capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req_d   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    err_d   = 1'b0;
    cnt_d   = '0;
`endif
    case (state_q)
      REQ_ST: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = HOLD_ST;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (timeout_hit) begin
          instr_d = NOP_INSTR;
          state_d = HOLD_ST;
          err_d   = 1'b1;
        end
`endif
      end
      HOLD_ST: begin
        if (instr_ready) begin
          pc_d    = PCSrc ? {Result[31:2], 2'b00} : pc_q + 32'd4;
          state_d = REQ_ST;
        end
      end
      default: state_d = REQ_ST;
    endcase
    // Request is a registered level: raised for every cycle spent in REQ_ST
    // after the entering edge, dropped on the edge that leaves REQ_ST.
    req_d = (state_d == REQ_ST);
`ifdef FETCH_TIMEOUT_EN
    // Counts consecutive REQ_ST cycles without ack; any state change clears it.
    if ((state_q == REQ_ST) && (state_d == REQ_ST)) begin
      cnt_d = cnt_q + CW'(1);
    end
`endif
  end

  // State, PC, request and instruction registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= REQ_ST;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= 32'h0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Timeout counter and the one-cycle error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetch_err = err_q;

  logic unused_bits;
  assign unused_bits = ^Result[1:0];
`else
  assign fetch_err = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{Result[1:0], (TIMEOUT_CYCLES > 0)};
`endif

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign Instr       = instr_q;
  assign instr_valid = (state_q == HOLD_ST);
  assign PC          = pc_q;
  assign PCPlus8     = pc_q + 32'd8;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by a randomized fetch/accept run.
// The reference model is a program counter advanced by the architectural rule
// (PC+4 or aligned branch target) plus a pure function giving the memory word
// at any address; every delivered Instr/PC is checked against it.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'hE1A0_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] Instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        PCSrc;
  logic [31:0] Result;
  logic [31:0] PC;
  logic [31:0] PCPlus8;
  logic        fetch_err;

  int vectors;
  int miscompares;

  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic [31:0] exp_q[$];

  fetch_unit #(
    .RESET_PC      (RST_PC),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .Instr      (Instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .PCSrc      (PCSrc),
    .Result     (Result),
    .PC         (PC),
    .PCPlus8    (PCPlus8),
    .fetch_err  (fetch_err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Waits lat cycles in REQ (inputs the DUT must ignore are toggled), then acks.
  task automatic fetch_one(input int lat);
    for (int i = 0; i < lat; i++) begin
      check_val("req_wait", {31'h0, imem_req}, 32'd1);
      check_val("addr_wait", imem_addr, exp_pc);
      check_val("valid_wait", {31'h0, instr_valid}, 32'd0);
      instr_ready = 1'($urandom_range(0, 1));
      PCSrc       = 1'($urandom_range(0, 1));
      Result      = $urandom;
      @(negedge clk);
      check_val("pc_wait", PC, exp_pc);
    end
    check_val("req", {31'h0, imem_req}, 32'd1);
    check_val("addr", imem_addr, exp_pc);
    exp_q.push_back(mem_word(exp_pc));
    imem_ack    = 1'b1;
    imem_rdata  = mem_word(exp_pc);
    instr_ready = 1'($urandom_range(0, 1));
    PCSrc       = 1'($urandom_range(0, 1));
    @(negedge clk);
    imem_ack    = 1'b0;
    imem_rdata  = $urandom;
    instr_ready = 1'b0;
    exp_instr   = exp_q.pop_front();
    check_val("valid_after_ack", {31'h0, instr_valid}, 32'd1);
    check_val("req_after_ack", {31'h0, imem_req}, 32'd0);
    check_val("instr", Instr, exp_instr);
    check_val("pc", PC, exp_pc);
    check_val("pcplus8", PCPlus8, exp_pc + 32'd8);
    check_val("err_after_ack", {31'h0, fetch_err}, 32'd0);
  endtask

  // Holds the instruction for n cycles with spurious acks and PCSrc noise.
  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      instr_ready = 1'b0;
      imem_ack    = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      PCSrc       = 1'($urandom_range(0, 1));
      Result      = $urandom;
      @(negedge clk);
      check_val("hold_valid", {31'h0, instr_valid}, 32'd1);
      check_val("hold_instr", Instr, exp_instr);
      check_val("hold_pc", PC, exp_pc);
      check_val("hold_req", {31'h0, imem_req}, 32'd0);
    end
    imem_ack = 1'b0;
  endtask

  task automatic accept(input logic src, input logic [31:0] res);
    instr_ready = 1'b1;
    PCSrc       = src;
    Result      = res;
    @(negedge clk);
    instr_ready = 1'b0;
    PCSrc       = 1'($urandom_range(0, 1));
    Result      = $urandom;
    exp_pc      = src ? (res & ~32'd3) : exp_pc + 32'd4;
    check_val("acc_valid", {31'h0, instr_valid}, 32'd0);
    check_val("acc_pc", PC, exp_pc);
    check_val("acc_pcplus8", PCPlus8, exp_pc + 32'd8);
    check_val("acc_req", {31'h0, imem_req}, 32'd1);
    check_val("acc_addr", imem_addr, exp_pc);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    Result      = 32'h0;
    exp_pc      = RST_PC;
    exp_instr   = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    check_val("rst_pc", PC, RST_PC);
    check_val("rst_pcplus8", PCPlus8, 32'h108);
    check_val("rst_req", {31'h0, imem_req}, 32'd0);
    check_val("rst_valid", {31'h0, instr_valid}, 32'd0);
    check_val("rst_instr", Instr, 32'h0);
    check_val("rst_err", {31'h0, fetch_err}, 32'd0);

    // Release: request rises one edge later at RESET_PC, ack after 2 cycles
    reset = 1'b1;
    check_val("rel_req_low", {31'h0, imem_req}, 32'd0);
    @(negedge clk);
    exp_q.push_back(32'hE3A0_1005);
    for (int i = 0; i < 2; i++) begin
      check_val("first_req", {31'h0, imem_req}, 32'd1);
      check_val("first_addr", imem_addr, 32'h100);
      @(negedge clk);
    end
    imem_ack   = 1'b1;
    imem_rdata = 32'hE3A0_1005;
    @(negedge clk);
    imem_ack   = 1'b0;
    exp_instr  = exp_q.pop_front();
    check_val("first_instr", Instr, exp_instr);
    check_val("first_valid", {31'h0, instr_valid}, 32'd1);
    check_val("first_pcplus8", PCPlus8, 32'h108);

    // Sequential accept, then branch with misaligned target
    accept(1'b0, 32'h0);
    check_val("seq_pc", PC, 32'h104);
    fetch_one(1);
    accept(1'b1, 32'h2003);
    check_val("br_pc", PC, 32'h2000);
    fetch_one(2);

    // Wrap: land on 0xFFFFFFFC, hold 5 cycles, then sequential accept wraps
    accept(1'b1, 32'hFFFF_FFFF);
    fetch_one(0);
    hold(5);
    accept(1'b0, 32'h0);
    check_val("wrap_pc", PC, 32'h0);
    check_val("wrap_pcplus8", PCPlus8, 32'h8);
    fetch_one(1);

    // Asynchronous reset in the middle of a request at PC=0x40
    accept(1'b1, 32'h40);
    #2;
    reset = 1'b0;
    #1;
    exp_pc = RST_PC;
    check_val("async_pc", PC, RST_PC);
    check_val("async_req", {31'h0, imem_req}, 32'd0);
    check_val("async_valid", {31'h0, instr_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    // Late ack right after release is taken as the RESET_PC fetch
    imem_ack   = 1'b1;
    imem_rdata = mem_word(RST_PC);
    @(negedge clk);
    imem_ack   = 1'b0;
    exp_instr  = mem_word(RST_PC);
    check_val("late_ack_valid", {31'h0, instr_valid}, 32'd1);
    check_val("late_ack_instr", Instr, exp_instr);
    check_val("late_ack_pc", PC, RST_PC);

`ifdef FETCH_TIMEOUT_EN
    // No ack: four REQ cycles, then NOP and a single error pulse
    accept(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("to_wait_valid", {31'h0, instr_valid}, 32'd0);
      check_val("to_wait_err", {31'h0, fetch_err}, 32'd0);
    end
    @(negedge clk);
    check_val("to_valid", {31'h0, instr_valid}, 32'd1);
    check_val("to_err", {31'h0, fetch_err}, 32'd1);
    check_val("to_instr", Instr, NOP);
    exp_instr = NOP;
    @(negedge clk);
    check_val("to_err_pulse", {31'h0, fetch_err}, 32'd0);
    // Ack on the fourth cycle wins over the timeout
    accept(1'b0, 32'h0);
    fetch_one(3);
`else
    @(negedge clk);
    check_val("err_tied", {31'h0, fetch_err}, 32'd0);
`endif

    // Randomized fetch/hold/accept traffic
    for (int n = 0; n < 300; n++) begin
      logic        src;
      logic [31:0] tgt;
      hold($urandom_range(0, 3));
      src = 1'($urandom_range(0, 1));
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
      accept(src, tgt);
      fetch_one($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
